axis_resizer_fifo: RTL
======================

# axis_resizer_fifo

Lane-granular AXI-Stream width converter with elastic storage, the parametrised successor to the fixed-ratio buffer block. It accepts S_KEEP_WIDTH-lane beats, compacts out null lanes (tkeep=0), and emits M_KEEP_WIDTH-lane beats that honour packet boundaries (tlast). Overflow and underflow are prevented by a ready/valid handshake. The block sits between the upstream stream source and the downstream consumer in the resizer datapath.

## Interface
- T_DATA_WIDTH, 8: bits per lane.
- S_KEEP_WIDTH, 3: slave lanes per beat, ≥1.
- M_KEEP_WIDTH, 2: master lanes per beat, ≥1.
- DEPTH, 16: storage in lanes, ≥ S_KEEP_WIDTH+M_KEEP_WIDTH. Need not be a power of two.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- s_tdata  in  S_KEEP_WIDTH*T_DATA_WIDTH  slave lanes; lane i is bits [i*T+:T].
- s_tkeep  in  S_KEEP_WIDTH  per-lane valid.
- s_tlast  in  1  end of packet.
- s_tvalid  in  1  slave beat valid.
- s_tready  out  1  slave beat accepted when s_tvalid&s_tready.
- m_tdata  out  M_KEEP_WIDTH*T_DATA_WIDTH  master lanes.
- m_tkeep  out  M_KEEP_WIDTH  contiguous low-order ones.
- m_tlast  out  1  last beat of packet.
- m_tvalid  out  1  master beat valid.
- m_tready  in  1  downstream ready.
- level  out  $clog2(DEPTH+1)  lanes currently stored.
- null_last  out  1  one-cycle pulse: an accepted beat had s_tkeep==0 and s_tlast=1.

## Operation
- Storage: DEPTH entries of {last, data[T_DATA_WIDTH]}. Registers: wptr, rptr (0..DEPTH-1), count (0..DEPTH), pkt_cnt (number of stored lanes with last=1, 0..DEPTH).
- Write: s_tready = (DEPTH-count ≥ S_KEEP_WIDTH), computed from registered count only (no read bypass). On acceptance, write n_w = popcount(s_tkeep) lanes.
  - Lanes are compacted in ascending lane index to wptr, wptr+1, … (mod DEPTH).
  - The highest kept lane gets last=s_tlast. All other written lanes get last=0.
- Null beat: s_tkeep==0 is accepted and writes nothing. If s_tlast=1 on such a beat, the tlast is discarded and null_last pulses on the next cycle.
- Read: m_tvalid = (count ≥ M_KEEP_WIDTH) || (pkt_cnt>0).
  - n_r = min(M_KEEP_WIDTH, count, d+1), where d is the offset from rptr to the first stored lane with last=1 (d=∞ if none).
  - m_tdata lane j = storage[rptr+j] for j<n_r, else 0.
  - m_tkeep = (1<<n_r)-1.
  - m_tlast = last flag of lane n_r-1.
- Pop: on m_tvalid&m_tready, advance rptr by n_r and decrement pkt_cnt by m_tlast.
- Arithmetic: pointer advance is mod DEPTH, implemented as subtract DEPTH when the sum ≥ DEPTH.
  - count_next = count + n_w − n_r, where each term is 0 if its handshake does not fire. A simultaneous read and write is always legal.
  - pkt_cnt_next follows the same rule.
- When m_tvalid=0: m_tdata=0, m_tkeep=0, m_tlast=0.
- level = count.

## Timing
- Reset (rst_n low): wptr=rptr=count=pkt_cnt=0 immediately. Outputs then read: s_tready=0, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, level=0, null_last=0.
  - Storage contents are not reset.
  - s_tready=1 from the first cycle after rst_n deasserts.
- Latency: a lane written at edge k is visible on m_* after edge k (first-word fall-through). Minimum slave-to-master latency is 1 cycle.
- m_* are combinational from registered state and stable while m_tvalid=1 and m_tready=0. s_tready does not depend on m_tready.
- Full: count > DEPTH−S_KEEP_WIDTH forces s_tready=0.
- Empty: m_tvalid=0 whenever count < M_KEEP_WIDTH and pkt_cnt=0. The held residual lanes stay until more lanes or a tlast arrive.
- Reset asserted mid-packet: the partial packet is lost. No m_tlast is emitted for it.

## Test plan
1. Default parameters: three full beats A..I (keep 111, tlast=0) with m_tready=1 → four beats {A,B},{C,D},{E,F},{G,H}, keep 11, tlast=0; I held with level=1 and m_tvalid=0.
2. Beat {A,B}, keep 011, tlast=1 → one master beat {A,B}, keep 11, tlast=1. Then beat {C,D,E}, keep 111, tlast=1 → {C,D} keep 11 tlast=0, then {E,0} keep 01 tlast=1.
3. Beat keep 101, lanes X,–,Z, tlast=1 → one master beat {X,Z}, keep 11, tlast=1; level returns to 0.
4. m_tready=0, DEPTH=16, continuous full beats → five beats accepted (level=15), s_tready=0. Then m_tready=1 for one cycle → level 13, s_tready=1.
5. Continuous s_tvalid and m_tready with keep 111 → steady state with level bounded ≤ DEPTH and output in strict input order. Add a null beat with tlast=1 → null_last pulses once and no data is written.
6. Assert rst_n=0 mid-packet with level=5 → same cycle: m_tvalid=0, level=0, s_tready=0. After release: s_tready=1, and a new packet passes cleanly.

Source files
------------

// File: rtl/axis_resizer_fifo.sv
// Lane-granular AXI-Stream width converter: compacts kept slave lanes into a
// circular lane store and emits master beats that never straddle a tlast.
module axis_resizer_fifo #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_KEEP_WIDTH = 3,
    parameter int M_KEEP_WIDTH = 2,
    parameter int DEPTH        = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [S_KEEP_WIDTH*T_DATA_WIDTH-1:0] s_tdata,
    input  logic [S_KEEP_WIDTH-1:0]              s_tkeep,
    input  logic                                 s_tlast,
    input  logic                                 s_tvalid,
    output logic                                 s_tready,
    output logic [M_KEEP_WIDTH*T_DATA_WIDTH-1:0] m_tdata,
    output logic [M_KEEP_WIDTH-1:0]              m_tkeep,
    output logic                                 m_tlast,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic [$clog2(DEPTH+1)-1:0]           level,
    output logic                                 null_last
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [T_DATA_WIDTH-1:0] mem_data [DEPTH];
    logic                    mem_last [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] pkt_cnt;

    logic [PW-1:0] wr_idx [S_KEEP_WIDTH];
    logic [PW-1:0] rd_idx [M_KEEP_WIDTH];
    int            n_w;
    int            n_r;
    int            hi_lane;
    int            wr_cnt;
    int            rd_cnt;
    logic          stop;
    logic          wr_fire;
    logic          rd_fire;
    logic          wr_pkt;
    logic          rd_pkt;

    // Offsets never exceed DEPTH, so one conditional subtract wraps correctly.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= DEPTH) sum = sum - DEPTH;
        return PW'(sum);
    endfunction

    // Each kept lane lands at wptr plus the number of kept lanes below it.
    always_comb begin
        n_w     = 0;
        hi_lane = 0;
        for (int i = 0; i < S_KEEP_WIDTH; i++) begin
            wr_idx[i] = wrap_add(wptr, n_w);
            if (s_tkeep[i]) begin
                n_w     = n_w + 1;
                hi_lane = i;
            end
        end
    end

    // A master beat stops early at the first stored last flag.
    always_comb begin
        n_r      = 0;
        stop     = 1'b0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        m_tvalid = (int'(count) >= M_KEEP_WIDTH) || (pkt_cnt != '0);
        for (int j = 0; j < M_KEEP_WIDTH; j++) begin
            rd_idx[j] = wrap_add(rptr, j);
            if (m_tvalid && !stop && (j < int'(count))) begin
                n_r                               = j + 1;
                m_tdata[j*T_DATA_WIDTH +: T_DATA_WIDTH] = mem_data[rd_idx[j]];
                m_tkeep[j]                        = 1'b1;
                m_tlast                           = mem_last[rd_idx[j]];
                if (mem_last[rd_idx[j]]) stop = 1'b1;
            end
        end
    end

    always_comb begin
        s_tready = rst_n && ((DEPTH - int'(count)) >= S_KEEP_WIDTH);
        wr_fire  = s_tvalid && s_tready;
        rd_fire  = m_tvalid && m_tready;
        wr_cnt   = wr_fire ? n_w : 0;
        rd_cnt   = rd_fire ? n_r : 0;
        wr_pkt   = wr_fire && s_tlast && (s_tkeep != '0);
        rd_pkt   = rd_fire && m_tlast;
        level    = count;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < S_KEEP_WIDTH; i++) begin
            if (wr_fire && s_tkeep[i]) begin
                mem_data[wr_idx[i]] <= s_tdata[i*T_DATA_WIDTH +: T_DATA_WIDTH];
                mem_last[wr_idx[i]] <= s_tlast && (i == hi_lane);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            pkt_cnt   <= '0;
            null_last <= 1'b0;
        end else begin
            wptr      <= wrap_add(wptr, wr_cnt);
            rptr      <= wrap_add(rptr, rd_cnt);
            count     <= CW'(int'(count) + wr_cnt - rd_cnt);
            pkt_cnt   <= CW'(int'(pkt_cnt) + int'(wr_pkt) - int'(rd_pkt));
            null_last <= wr_fire && (s_tkeep == '0) && s_tlast;
        end
    end

endmodule
